mem_queue_ctrl: RTL and testbench

Valid/ready FIFO controller that uses an external 32×64 one-read/one-write memory as its storage, and sits directly in front of that memory. The memory's read port registers its address, so data appears one cycle after the address is presented. Its write port writes unconditionally every cycle. This block drives both memory ports, hides the read latency behind a 2-entry output buffer, and presents a streaming enqueue/dequeue interface at full throughput.

---
 rtl/mem_queue_ctrl.sv | 107 ++++++++++
 tb/tb_mem_queue_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_queue_ctrl.sv
// Valid/ready FIFO controller in front of an external 1R1W memory with a
// registered read address; a 2-entry output buffer hides the read latency.
module mem_queue_ctrl #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_data,
    output logic [5:0]        count,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] MEM_MAX = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] mem_cnt_q, mem_cnt_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        ob_cnt_q, ob_cnt_d;
    logic [DATA_W-1:0] ob0_q, ob0_d;
    logic [DATA_W-1:0] ob1_q, ob1_d;

    logic       enq_fire;
    logic       deq_fire;
    logic       fetch;
    logic [2:0] ob_occ;

    // The write slot is always free, so the memory holds at most DEPTH-1.
    assign enq_ready = reset & (mem_cnt_q != MEM_MAX);
    assign deq_valid = reset & (ob_cnt_q != 2'd0);
    assign deq_data  = ob0_q;
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid & deq_ready;

    assign mem_raddr = rd_ptr_q;
    assign mem_waddr = wr_ptr_q;
    assign mem_wdata = enq_data;

    assign ob_occ = {1'b0, ob_cnt_q} + {2'b00, inflight_q};
    assign fetch  = (mem_cnt_q != '0) &
                    (ob_occ < (3'd2 + {2'b00, deq_fire}));

    assign count = 6'(mem_cnt_q) + 6'(inflight_q) + 6'(ob_cnt_q);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = fetch;
        mem_cnt_d  = mem_cnt_q + ADDR_W'(enq_fire) - ADDR_W'(fetch);
        ob_cnt_d   = ob_cnt_q + 2'(inflight_q) - 2'(deq_fire);
        ob0_d      = ob0_q;
        ob1_d      = ob1_q;
        if (enq_fire) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (fetch) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({inflight_q, deq_fire})
            2'b01: ob0_d = ob1_q;
            2'b10: begin
                if (ob_cnt_q == 2'd0) begin
                    ob0_d = mem_rdata;
                end else begin
                    ob1_d = mem_rdata;
                end
            end
            2'b11: begin
                if (ob_cnt_q == 2'd1) begin
                    ob0_d = mem_rdata;
                end else begin
                    ob0_d = ob1_q;
                    ob1_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            inflight_q <= 1'b0;
            ob_cnt_q   <= 2'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            inflight_q <= inflight_d;
            ob_cnt_q   <= ob_cnt_d;
        end
        ob0_q <= ob0_d;
        ob1_q <= ob1_d;
    end

endmodule

// File: tb/tb_mem_queue_ctrl.sv
// Bench for mem_queue_ctrl: behavioural memory plus a queue scoreboard
// that tracks held entries as accepted minus taken.
module tb_mem_queue_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [63:0] enq_data = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [63:0] deq_data;
    logic [5:0]  count;
    logic [4:0]  mem_raddr;
    logic [63:0] mem_rdata;
    logic [4:0]  mem_waddr;
    logic [63:0] mem_wdata;

    logic [63:0] mem [32];
    logic [4:0]  raddr_q;

    logic [63:0] model_q[$];
    int          errors = 0;
    int          checks = 0;
    int          popped = 0;

    always #5 clock = ~clock;

    mem_queue_ctrl #(.DATA_W(64), .ADDR_W(5)) dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
        .count(count),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    always @(posedge clock) begin
        raddr_q <= mem_raddr;
        mem[mem_waddr] <= mem_wdata;
    end
    assign mem_rdata = mem[raddr_q];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input logic ev, input logic [63:0] ed,
                         input logic dr, input int exp_dv, input int exp_er);
        enq_valid = ev;
        enq_data  = ed;
        deq_ready = dr;
        #1;
        chk("count", 64'(count), 64'(model_q.size()));
        if (model_q.size() == 0) chk("deq_valid_empty", 64'(deq_valid), 0);
        if (exp_dv >= 0) chk("deq_valid", 64'(deq_valid), 64'(exp_dv));
        if (exp_er >= 0) chk("enq_ready", 64'(enq_ready), 64'(exp_er));
        if (deq_valid && dr) begin
            if (model_q.size() == 0) begin
                chk("deq_underflow", 64'(model_q.size()), 1);
            end else begin
                chk("deq_data", deq_data, model_q[0]);
                void'(model_q.pop_front());
            end
            popped++;
        end
        if (ev && enq_ready) model_q.push_back(ed);
        @(negedge clock);
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            enq_valid = 1'b1;
            enq_data  = rnd64();
            deq_ready = 1'b1;
            #1;
            chk("rst_enq_ready", 64'(enq_ready), 0);
            chk("rst_deq_valid", 64'(deq_valid), 0);
            @(negedge clock);
        end
        reset = 1'b1;
        model_q.delete();
        enq_valid = 1'b0;
        #1;
        chk("rst_count", 64'(count), 0);
        chk("rst_deq_valid_after", 64'(deq_valid), 0);
        chk("rst_enq_ready_after", 64'(enq_ready), 1);
        chk("rst_raddr", 64'(mem_raddr), 0);
        chk("rst_waddr", 64'(mem_waddr), 0);
    endtask

    initial begin
        int pushed;
        int n;
        @(negedge clock);
        do_reset(2);

        // single entry latency
        cycle(1'b1, 64'hDEAD_BEEF, 1'b1, 0, 1);
        cycle(1'b0, rnd64(), 1'b1, 0, -1);
        chk("single_count_c1", 64'(count), 1);
        cycle(1'b0, rnd64(), 1'b1, 0, -1);
        chk("single_count_c2", 64'(count), 1);
        #1;
        chk("single_data_c3", deq_data, 64'hDEAD_BEEF);
        cycle(1'b0, rnd64(), 1'b1, 1, -1);
        chk("single_count_after", 64'(count), 0);

        // streaming, full throughput
        for (int i = 0; i < 106; i++) begin
            cycle(i < 100, 64'(i), 1'b1,
                  (i >= 3 && i <= 102) ? 1 : 0, (i < 100) ? 1 : -1);
        end
        chk("stream_popped", 64'(popped), 101);

        // fill to 33, then idle with changing write data, then drain
        for (int i = 0; i < 40; i++) begin
            n = (model_q.size() != 33) ? 1 : 0;
            cycle(1'b1, rnd64(), 1'b0, -1, n);
        end
        chk("fill_count", 64'(count), 33);
        chk("fill_enq_ready", 64'(enq_ready), 0);
        for (int i = 0; i < 40; i++) cycle(1'b0, rnd64(), 1'b0, 1, 0);
        popped = 0;
        n = 0;
        while (model_q.size() != 0 && n < 60) begin
            cycle(1'b0, rnd64(), 1'b1, -1, -1);
            n++;
        end
        chk("drain_popped", 64'(popped), 33);
        cycle(1'b0, rnd64(), 1'b1, 0, 1);

        // random traffic across pointer wrap
        pushed = 0;
        n = 0;
        while ((pushed < 200 || model_q.size() != 0) && n < 5000) begin
            logic ev;
            ev = (pushed < 200) && ($urandom_range(0, 3) != 0);
            if (ev && enq_ready) pushed++;
            cycle(ev, rnd64(), $urandom_range(0, 2) != 0, -1, -1);
            n++;
        end
        chk("random_done", 64'(n < 5000), 1);
        chk("random_pushed", 64'(pushed), 200);

        // reset while a read is in flight
        cycle(1'b1, 64'h1111, 1'b0, -1, 1);
        cycle(1'b1, 64'h2222, 1'b0, -1, 1);
        cycle(1'b1, 64'h3333, 1'b0, -1, 1);
        #1;
        chk("pre_rst_count", 64'(count), 3);
        chk("pre_rst_deq_valid", 64'(deq_valid), 1);
        do_reset(1);
        cycle(1'b1, 64'h5A, 1'b1, 0, 1);
        cycle(1'b0, rnd64(), 1'b1, 0, -1);
        cycle(1'b0, rnd64(), 1'b1, 0, -1);
        #1;
        chk("post_rst_data", deq_data, 64'h5A);
        cycle(1'b0, rnd64(), 1'b1, 1, -1);
        cycle(1'b0, rnd64(), 1'b1, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
